// File: rtl/beat_timer_pkg.sv
// Shared types and defaults for the MUSIC beat timer.
// Swing timing is enabled by defining BEAT_TIMER_SWING_EN.
package beat_timer_pkg;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_SPEED_W = 2;
  localparam int DEF_NB_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // A zero-length beat would never tick, so it becomes one cycle.
  function automatic logic [63:0] clamp_p(input logic [63:0] p);
    return (p == 64'd0) ? 64'd1 : p;
  endfunction

endpackage

// File: rtl/beat_period_calc.sv
// Beat period from the latched length and tempo shift.
// With BEAT_TIMER_SWING_EN, even beats stretch and odd beats shrink by P/4.
module beat_period_calc
  import beat_timer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SPEED_W = DEF_SPEED_W
) (
  input  logic [CNT_W-1:0]   beat_len_i,
  input  logic [SPEED_W-1:0] speed_i,
`ifdef BEAT_TIMER_SWING_EN
  input  logic               swing_i,
  input  logic               odd_i,
`endif
  output logic [CNT_W-1:0]   period_o
);

  logic [63:0] base;
  logic [63:0] adj;
  logic [63:0] lim;

  always_comb begin
    base = 64'(beat_len_i >> speed_i);
    adj  = base;
`ifdef BEAT_TIMER_SWING_EN
    if (swing_i) begin
      adj = odd_i ? base - (base >> 2) : base + (base >> 2);
    end
`endif
    // A stretched beat saturates rather than wrapping the counter.
    lim = (64'd1 << CNT_W) - 64'd1;
    if (adj > lim) begin
      adj = lim;
    end
    period_o = CNT_W'(clamp_p(adj));
  end

endmodule

// File: rtl/beat_timer.sv
// Note timer: N beats of P cycles, beat tick and note-done pulses.
// Optional swing input exists only when BEAT_TIMER_SWING_EN is defined.
module beat_timer
  import beat_timer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SPEED_W = DEF_SPEED_W,
  parameter int NB_W    = DEF_NB_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [CNT_W-1:0]   beat_len,
  input  logic [SPEED_W-1:0] speed,
  input  logic [NB_W-1:0]    num_beats,
`ifdef BEAT_TIMER_SWING_EN
  input  logic               swing,
`endif
  output logic               busy,
  output logic               beat_tick,
  output logic               note_done,
  output logic [NB_W-1:0]    beat_idx
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [NB_W-1:0]    nb_q, nb_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               sw_q, sw_d;
  logic               sw_in;
  logic [CNT_W-1:0]   period;
  logic               running;
  logic               at_end;
  logic               last;

`ifdef BEAT_TIMER_SWING_EN
  assign sw_in = swing;
`else
  assign sw_in = 1'b0;
`endif

  beat_period_calc #(
    .CNT_W   (CNT_W),
    .SPEED_W (SPEED_W)
  ) u_calc (
    .beat_len_i (len_q),
    .speed_i    (spd_q),
`ifdef BEAT_TIMER_SWING_EN
    .swing_i    (sw_q),
    .odd_i      (idx_q[0]),
`endif
    .period_o   (period)
  );

  assign running = (state_q != ST_IDLE);
  assign at_end  = (cnt_q == period - CNT_W'(1));
  assign last    = (idx_q == nb_q - NB_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    spd_d   = spd_q;
    nb_d    = nb_q;
    sw_d    = sw_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (start) begin
      // A restart on the final tick still reports the old note's end.
      if (running && !pause && at_end) begin
        tick_d = 1'b1;
        done_d = last;
      end
      state_d = ST_RUN;
      cnt_d   = '0;
      idx_d   = '0;
      len_d   = beat_len;
      spd_d   = speed;
      nb_d    = (num_beats == '0) ? NB_W'(1) : num_beats;
      sw_d    = sw_in;
    end else if (running) begin
      if (pause) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_RUN;
        if (at_end) begin
          tick_d = 1'b1;
          cnt_d  = '0;
          if (last) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + NB_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      spd_q   <= '0;
      nb_q    <= '0;
      sw_q    <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      spd_q   <= spd_d;
      nb_q    <= nb_d;
      sw_q    <= sw_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Busy covers the note_done cycle so it drops the cycle after.
  assign busy      = running | done_q;
  assign beat_tick = tick_q;
  assign note_done = done_q;
  assign beat_idx  = idx_q;

endmodule

// File: tb/tb_beat_timer.sv
// Scoreboard bench for beat_timer; swing scenario built with BEAT_TIMER_SWING_EN.
module tb_beat_timer;

  localparam int CNT_W   = 28;
  localparam int SPEED_W = 2;
  localparam int NB_W    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               pause;
  logic [CNT_W-1:0]   beat_len;
  logic [SPEED_W-1:0] speed;
  logic [NB_W-1:0]    num_beats;
  logic               swing;
  logic               busy;
  logic               beat_tick;
  logic               note_done;
  logic [NB_W-1:0]    beat_idx;

  typedef struct {
    int cyc;
    bit done;
    int idx;
  } ev_t;

  ev_t sbq[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  always #5 clk = ~clk;

  beat_timer #(
    .CNT_W   (CNT_W),
    .SPEED_W (SPEED_W),
    .NB_W    (NB_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .beat_len  (beat_len),
    .speed     (speed),
    .num_beats (num_beats),
`ifdef BEAT_TIMER_SWING_EN
    .swing     (swing),
`endif
    .busy      (busy),
    .beat_tick (beat_tick),
    .note_done (note_done),
    .beat_idx  (beat_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(int c, bit d, int i);
    ev_t e;
    e.cyc  = c;
    e.done = d;
    e.idx  = i;
    sbq.push_back(e);
  endtask

  // Reference timing: expected tick cycles for one note starting at t0.
  task automatic push_note(int t0, int p, int nb, bit sw);
    int t;
    int len;
    t = t0;
    for (int k = 0; k < nb; k++) begin
      len = p;
      if (sw) len = (k % 2 == 0) ? p + p / 4 : p - p / 4;
      if (len < 1) len = 1;
      t += len;
      push(t, k == nb - 1, (k == nb - 1) ? 0 : k + 1);
    end
  endtask

  task automatic start_note(int bl, int sp, int nb, bit sw);
    beat_len  = CNT_W'(bl);
    speed     = SPEED_W'(sp);
    num_beats = NB_W'(nb);
    swing     = sw;
    start     = 1'b1;
    step();
    cyc   = 0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    compared += 4;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (beat_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_tick got=%b exp=0", beat_tick);
    end
    if (note_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_done got=%b exp=0", note_done);
    end
    if (beat_idx !== '0) begin
      mismatched++;
      $display("FAIL reset_idx got=%0d exp=0", beat_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    ev_t ev;
    start_note(10, 0, 3, 0);
    push_note(0, 10, 3, 0);
    beat_len  = CNT_W'(3);
    num_beats = NB_W'(7);
    for (int e = 1; e <= 34; e++) begin
      step();
      compared++;
      if (busy !== (e <= 30)) begin
        mismatched++;
        $display("FAIL basic_busy cyc=%0d got=%b exp=%b", e, busy, e <= 30);
      end
      if (beat_tick) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL basic_extra_tick cyc=%0d", e);
        end else begin
          ev = sbq.pop_front();
          if (e !== ev.cyc || note_done !== ev.done
              || int'(beat_idx) !== ev.idx) begin
            mismatched++;
            $display("FAIL basic_tick got cyc=%0d done=%b idx=%0d exp cyc=%0d done=%b idx=%0d",
                     e, note_done, beat_idx, ev.cyc, ev.done, ev.idx);
          end
        end
      end
    end
    compared++;
    if (sbq.size() !== 0) begin
      mismatched++;
      $display("FAIL basic_missing_ticks got=%0d left exp=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_speed();
    ev_t ev;
    int bl[3] = '{10, 1, 1};
    int sp[3] = '{1, 3, 0};
    int nb[3] = '{2, 0, 3};
    int pp[3] = '{5, 1, 1};
    int nn[3] = '{2, 1, 3};
    for (int r = 0; r < 3; r++) begin
      start_note(bl[r], sp[r], nb[r], 0);
      push_note(0, pp[r], nn[r], 0);
      for (int e = 1; e <= 14; e++) begin
        step();
        if (beat_tick) begin
          compared++;
          if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL speed_extra_tick run=%0d cyc=%0d", r, e);
          end else begin
            ev = sbq.pop_front();
            if (e !== ev.cyc || note_done !== ev.done
                || int'(beat_idx) !== ev.idx) begin
              mismatched++;
              $display("FAIL speed_tick run=%0d got cyc=%0d done=%b exp cyc=%0d done=%b",
                       r, e, note_done, ev.cyc, ev.done);
            end
          end
        end
      end
      compared++;
      if (sbq.size() !== 0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL speed_end run=%0d got left=%0d busy=%b exp 0/0", r, sbq.size(), busy);
        sbq.delete();
      end
    end
  endtask

  task automatic test_pause();
    ev_t ev;
    start_note(8, 0, 4, 0);
    push(8, 0, 1);
    push(22, 0, 2);
    push(30, 0, 3);
    push(38, 1, 0);
    for (int e = 1; e <= 42; e++) begin
      step();
      if (e == 11) pause = 1'b1;
      if (e == 17) pause = 1'b0;
      if (e == 15) begin
        compared++;
        if (busy !== 1'b1 || int'(beat_idx) !== 1) begin
          mismatched++;
          $display("FAIL pause_hold got busy=%b idx=%0d exp 1/1", busy, beat_idx);
        end
      end
      if (beat_tick) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL pause_extra_tick cyc=%0d", e);
        end else begin
          ev = sbq.pop_front();
          if (e !== ev.cyc || note_done !== ev.done
              || int'(beat_idx) !== ev.idx) begin
            mismatched++;
            $display("FAIL pause_tick got cyc=%0d done=%b exp cyc=%0d done=%b",
                     e, note_done, ev.cyc, ev.done);
          end
        end
      end
    end
    pause = 1'b1;
    step();
    step();
    compared++;
    if (sbq.size() !== 0 || busy !== 1'b0 || beat_tick !== 1'b0) begin
      mismatched++;
      $display("FAIL pause_end got left=%0d busy=%b tick=%b exp 0/0/0",
               sbq.size(), busy, beat_tick);
      sbq.delete();
    end
    pause = 1'b0;
  endtask

  task automatic test_stop();
    ev_t ev;
    for (int r = 0; r < 2; r++) begin
      start_note(8, 0, 4, 0);
      push(8, 0, 1);
      for (int e = 1; e <= 30; e++) begin
        step();
        if (r == 0 && e == 15) stop = 1'b1;
        if (r == 0 && e == 16) begin
          stop = 1'b0;
          compared++;
          if (busy !== 1'b0 || beat_idx !== '0) begin
            mismatched++;
            $display("FAIL stop_idle got busy=%b idx=%0d exp 0/0", busy, beat_idx);
          end
        end
        if (r == 1 && e == 10) begin
          rst = 1'b1;
          #1;
          compared++;
          if (busy !== 1'b0 || beat_idx !== '0 || beat_tick !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid got busy=%b idx=%0d tick=%b exp 0/0/0",
                     busy, beat_idx, beat_tick);
          end
          rst = 1'b0;
        end
        if (beat_tick || note_done) begin
          compared++;
          if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL stop_extra_pulse run=%0d cyc=%0d tick=%b done=%b",
                     r, e, beat_tick, note_done);
          end else begin
            ev = sbq.pop_front();
            if (e !== ev.cyc || note_done !== ev.done) begin
              mismatched++;
              $display("FAIL stop_tick got cyc=%0d exp cyc=%0d", e, ev.cyc);
            end
          end
        end
      end
      compared++;
      if (sbq.size() !== 0) begin
        mismatched++;
        $display("FAIL stop_missing run=%0d got=%0d exp=0", r, sbq.size());
        sbq.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t ev;
    start_note(4, 0, 2, 0);
    push_note(0, 4, 2, 0);
    push_note(8, 4, 2, 0);
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 7) start = 1'b1;
      if (e == 8) start = 1'b0;
      compared++;
      if (busy !== (e <= 16)) begin
        mismatched++;
        $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", e, busy, e <= 16);
      end
      if (beat_tick) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL b2b_extra_tick cyc=%0d", e);
        end else begin
          ev = sbq.pop_front();
          if (e !== ev.cyc || note_done !== ev.done
              || int'(beat_idx) !== ev.idx) begin
            mismatched++;
            $display("FAIL b2b_tick got cyc=%0d done=%b idx=%0d exp cyc=%0d done=%b idx=%0d",
                     e, note_done, beat_idx, ev.cyc, ev.done, ev.idx);
          end
        end
      end
    end
    compared++;
    if (sbq.size() !== 0) begin
      mismatched++;
      $display("FAIL b2b_missing got=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask

`ifdef BEAT_TIMER_SWING_EN
  task automatic test_swing();
    ev_t ev;
    start_note(8, 0, 4, 1);
    push_note(0, 8, 4, 1);
    for (int e = 1; e <= 36; e++) begin
      step();
      if (beat_tick) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL swing_extra_tick cyc=%0d", e);
        end else begin
          ev = sbq.pop_front();
          if (e !== ev.cyc || note_done !== ev.done) begin
            mismatched++;
            $display("FAIL swing_tick got cyc=%0d done=%b exp cyc=%0d done=%b",
                     e, note_done, ev.cyc, ev.done);
          end
        end
      end
    end
    compared++;
    if (sbq.size() !== 0) begin
      mismatched++;
      $display("FAIL swing_missing got=%0d exp=0", sbq.size());
      sbq.delete();
    end
  endtask
`endif

  initial begin
    start     = 1'b0;
    stop      = 1'b0;
    pause     = 1'b0;
    swing     = 1'b0;
    beat_len  = '0;
    speed     = '0;
    num_beats = '0;
    test_reset();
    test_basic();
    test_speed();
    test_pause();
    test_stop();
    test_back_to_back();
`ifdef BEAT_TIMER_SWING_EN
    test_swing();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
